// File: rtl/axi4_arb_pkg.sv
// Shared definitions for the two-master AXI4 arbiter.
//   - Fabric widths (address, data, ID, burst length).
//   - State encodings for the independent write and read FSMs.
package axi4_arb_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int ID_W   = 4;
    localparam int LEN_W  = 8;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_ADDR = 2'd1,
        W_DATA = 2'd2,
        W_RESP = 2'd3
    } wstate_e;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_DATA = 2'd2
    } rstate_e;

endpackage

// File: rtl/axi4_arb_rr2.sv
// Two-way combinational request picker.
// Ports:
//   req_i        - request from master 0 (bit 0) and master 1 (bit 1)
//   last_i       - index of the master that won the previous arbitration
//   fixed_prio_i - 1: master 0 always wins a tie; 0: alternate on ties
//   winner_o     - index of the chosen master (don't-care when req_i == 0)
module axi4_arb_rr2 (
    input  logic [1:0] req_i,
    input  logic       last_i,
    input  logic       fixed_prio_i,
    output logic       winner_o
);

    always_comb begin
        winner_o = 1'b0;
        case (req_i)
            2'b10:   winner_o = 1'b1;
            // Tie: hand the grant to whoever did not win last time.
            2'b11:   winner_o = fixed_prio_i ? 1'b0 : ~last_i;
            default: winner_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/axi4_arb2.sv
// Two-master to one-slave AXI4 arbiter. Write and read paths are arbitrated
// independently, each allowing a single outstanding transaction so that
// responses route back by grant alone (no ID remapping).
// Ports:
//   clk_i, rst_ni  - clock, asynchronous active-low reset
//   inport0_*      - master 0 AXI4 bundle (AW, W, B, AR, R)
//   inport1_*      - master 1 AXI4 bundle, same shape
//   outport_*      - downstream AXI4 bundle toward the slave
// Parameter:
//   FIXED_PRIO     - 0: round-robin on ties; 1: master 0 always wins ties
module axi4_arb2
    import axi4_arb_pkg::*;
#(
    parameter int unsigned FIXED_PRIO = 0
) (
    input  logic              clk_i,
    input  logic              rst_ni,

    // master 0
    input  logic              inport0_awvalid_i,
    input  logic [ADDR_W-1:0] inport0_awaddr_i,
    input  logic [ID_W-1:0]   inport0_awid_i,
    input  logic [LEN_W-1:0]  inport0_awlen_i,
    input  logic [1:0]        inport0_awburst_i,
    output logic              inport0_awready_o,
    input  logic              inport0_wvalid_i,
    input  logic [DATA_W-1:0] inport0_wdata_i,
    input  logic [3:0]        inport0_wstrb_i,
    input  logic              inport0_wlast_i,
    output logic              inport0_wready_o,
    output logic              inport0_bvalid_o,
    output logic [1:0]        inport0_bresp_o,
    output logic [ID_W-1:0]   inport0_bid_o,
    input  logic              inport0_bready_i,
    input  logic              inport0_arvalid_i,
    input  logic [ADDR_W-1:0] inport0_araddr_i,
    input  logic [ID_W-1:0]   inport0_arid_i,
    input  logic [LEN_W-1:0]  inport0_arlen_i,
    input  logic [1:0]        inport0_arburst_i,
    output logic              inport0_arready_o,
    output logic              inport0_rvalid_o,
    output logic [DATA_W-1:0] inport0_rdata_o,
    output logic [1:0]        inport0_rresp_o,
    output logic [ID_W-1:0]   inport0_rid_o,
    output logic              inport0_rlast_o,
    input  logic              inport0_rready_i,

    // master 1
    input  logic              inport1_awvalid_i,
    input  logic [ADDR_W-1:0] inport1_awaddr_i,
    input  logic [ID_W-1:0]   inport1_awid_i,
    input  logic [LEN_W-1:0]  inport1_awlen_i,
    input  logic [1:0]        inport1_awburst_i,
    output logic              inport1_awready_o,
    input  logic              inport1_wvalid_i,
    input  logic [DATA_W-1:0] inport1_wdata_i,
    input  logic [3:0]        inport1_wstrb_i,
    input  logic              inport1_wlast_i,
    output logic              inport1_wready_o,
    output logic              inport1_bvalid_o,
    output logic [1:0]        inport1_bresp_o,
    output logic [ID_W-1:0]   inport1_bid_o,
    input  logic              inport1_bready_i,
    input  logic              inport1_arvalid_i,
    input  logic [ADDR_W-1:0] inport1_araddr_i,
    input  logic [ID_W-1:0]   inport1_arid_i,
    input  logic [LEN_W-1:0]  inport1_arlen_i,
    input  logic [1:0]        inport1_arburst_i,
    output logic              inport1_arready_o,
    output logic              inport1_rvalid_o,
    output logic [DATA_W-1:0] inport1_rdata_o,
    output logic [1:0]        inport1_rresp_o,
    output logic [ID_W-1:0]   inport1_rid_o,
    output logic              inport1_rlast_o,
    input  logic              inport1_rready_i,

    // downstream slave
    output logic              outport_awvalid_o,
    output logic [ADDR_W-1:0] outport_awaddr_o,
    output logic [ID_W-1:0]   outport_awid_o,
    output logic [LEN_W-1:0]  outport_awlen_o,
    output logic [1:0]        outport_awburst_o,
    input  logic              outport_awready_i,
    output logic              outport_wvalid_o,
    output logic [DATA_W-1:0] outport_wdata_o,
    output logic [3:0]        outport_wstrb_o,
    output logic              outport_wlast_o,
    input  logic              outport_wready_i,
    input  logic              outport_bvalid_i,
    input  logic [1:0]        outport_bresp_i,
    input  logic [ID_W-1:0]   outport_bid_i,
    output logic              outport_bready_o,
    output logic              outport_arvalid_o,
    output logic [ADDR_W-1:0] outport_araddr_o,
    output logic [ID_W-1:0]   outport_arid_o,
    output logic [LEN_W-1:0]  outport_arlen_o,
    output logic [1:0]        outport_arburst_o,
    input  logic              outport_arready_i,
    input  logic              outport_rvalid_i,
    input  logic [DATA_W-1:0] outport_rdata_i,
    input  logic [1:0]        outport_rresp_i,
    input  logic [ID_W-1:0]   outport_rid_i,
    input  logic              outport_rlast_i,
    output logic              outport_rready_o
);

    wstate_e wstate_q, wstate_d;
    rstate_e rstate_q, rstate_d;
    logic    wgrant_q, wgrant_d;
    logic    rgrant_q, rgrant_d;
    // Index of the master that completed the previous transaction on each path.
    logic    wwin_q, wwin_d;
    logic    rwin_q, rwin_d;

    logic    w_winner, r_winner;

    // Granted master's handshake signals, selected once for reuse below.
    logic    aw_valid_sel, w_valid_sel, w_last_sel, b_ready_sel;
    logic    ar_valid_sel, r_ready_sel;

    axi4_arb_rr2 u_wpick (
        .req_i        ({inport1_awvalid_i, inport0_awvalid_i}),
        .last_i       (wwin_q),
        .fixed_prio_i (FIXED_PRIO != 0),
        .winner_o     (w_winner)
    );

    axi4_arb_rr2 u_rpick (
        .req_i        ({inport1_arvalid_i, inport0_arvalid_i}),
        .last_i       (rwin_q),
        .fixed_prio_i (FIXED_PRIO != 0),
        .winner_o     (r_winner)
    );

    assign aw_valid_sel = wgrant_q ? inport1_awvalid_i : inport0_awvalid_i;
    assign w_valid_sel  = wgrant_q ? inport1_wvalid_i  : inport0_wvalid_i;
    assign w_last_sel   = wgrant_q ? inport1_wlast_i   : inport0_wlast_i;
    assign b_ready_sel  = wgrant_q ? inport1_bready_i  : inport0_bready_i;
    assign ar_valid_sel = rgrant_q ? inport1_arvalid_i : inport0_arvalid_i;
    assign r_ready_sel  = rgrant_q ? inport1_rready_i  : inport0_rready_i;

    // Payload muxes: don't-care while the matching valid is low.
    assign outport_awaddr_o  = wgrant_q ? inport1_awaddr_i  : inport0_awaddr_i;
    assign outport_awid_o    = wgrant_q ? inport1_awid_i    : inport0_awid_i;
    assign outport_awlen_o   = wgrant_q ? inport1_awlen_i   : inport0_awlen_i;
    assign outport_awburst_o = wgrant_q ? inport1_awburst_i : inport0_awburst_i;
    assign outport_wdata_o   = wgrant_q ? inport1_wdata_i   : inport0_wdata_i;
    assign outport_wstrb_o   = wgrant_q ? inport1_wstrb_i   : inport0_wstrb_i;
    assign outport_wlast_o   = w_last_sel;
    assign outport_araddr_o  = rgrant_q ? inport1_araddr_i  : inport0_araddr_i;
    assign outport_arid_o    = rgrant_q ? inport1_arid_i    : inport0_arid_i;
    assign outport_arlen_o   = rgrant_q ? inport1_arlen_i   : inport0_arlen_i;
    assign outport_arburst_o = rgrant_q ? inport1_arburst_i : inport0_arburst_i;

    // Response payload fans out to both masters; only bvalid/rvalid are gated.
    assign inport0_bresp_o = outport_bresp_i;
    assign inport0_bid_o   = outport_bid_i;
    assign inport1_bresp_o = outport_bresp_i;
    assign inport1_bid_o   = outport_bid_i;
    assign inport0_rdata_o = outport_rdata_i;
    assign inport0_rresp_o = outport_rresp_i;
    assign inport0_rid_o   = outport_rid_i;
    assign inport0_rlast_o = outport_rlast_i;
    assign inport1_rdata_o = outport_rdata_i;
    assign inport1_rresp_o = outport_rresp_i;
    assign inport1_rid_o   = outport_rid_i;
    assign inport1_rlast_o = outport_rlast_i;

    // Last-winner registers reset to 1 so master 0 takes the first tie.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wstate_q <= W_IDLE;
            rstate_q <= R_IDLE;
            wgrant_q <= 1'b0;
            rgrant_q <= 1'b0;
            wwin_q   <= 1'b1;
            rwin_q   <= 1'b1;
        end else begin
            wstate_q <= wstate_d;
            rstate_q <= rstate_d;
            wgrant_q <= wgrant_d;
            rgrant_q <= rgrant_d;
            wwin_q   <= wwin_d;
            rwin_q   <= rwin_d;
        end
    end

    // Write path FSM: all handshake outputs default low so a stray B is held off.
    always_comb begin
        wstate_d          = wstate_q;
        wgrant_d          = wgrant_q;
        wwin_d            = wwin_q;
        outport_awvalid_o = 1'b0;
        outport_wvalid_o  = 1'b0;
        outport_bready_o  = 1'b0;
        inport0_awready_o = 1'b0;
        inport1_awready_o = 1'b0;
        inport0_wready_o  = 1'b0;
        inport1_wready_o  = 1'b0;
        inport0_bvalid_o  = 1'b0;
        inport1_bvalid_o  = 1'b0;
        case (wstate_q)
            W_IDLE: begin
                if (inport0_awvalid_i || inport1_awvalid_i) begin
                    wgrant_d = w_winner;
                    wstate_d = W_ADDR;
                end
            end
            W_ADDR: begin
                outport_awvalid_o = aw_valid_sel;
                inport0_awready_o = ~wgrant_q & outport_awready_i;
                inport1_awready_o =  wgrant_q & outport_awready_i;
                if (aw_valid_sel && outport_awready_i) wstate_d = W_DATA;
            end
            W_DATA: begin
                outport_wvalid_o  = w_valid_sel;
                inport0_wready_o  = ~wgrant_q & outport_wready_i;
                inport1_wready_o  =  wgrant_q & outport_wready_i;
                // Burst length is not counted; wlast alone closes the burst.
                if (w_valid_sel && outport_wready_i && w_last_sel) wstate_d = W_RESP;
            end
            W_RESP: begin
                outport_bready_o  = b_ready_sel;
                inport0_bvalid_o  = ~wgrant_q & outport_bvalid_i;
                inport1_bvalid_o  =  wgrant_q & outport_bvalid_i;
                if (outport_bvalid_i && b_ready_sel) begin
                    wwin_d   = wgrant_q;
                    wstate_d = W_IDLE;
                end
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    // Read path FSM: independent of the write path.
    always_comb begin
        rstate_d          = rstate_q;
        rgrant_d          = rgrant_q;
        rwin_d            = rwin_q;
        outport_arvalid_o = 1'b0;
        outport_rready_o  = 1'b0;
        inport0_arready_o = 1'b0;
        inport1_arready_o = 1'b0;
        inport0_rvalid_o  = 1'b0;
        inport1_rvalid_o  = 1'b0;
        case (rstate_q)
            R_IDLE: begin
                if (inport0_arvalid_i || inport1_arvalid_i) begin
                    rgrant_d = r_winner;
                    rstate_d = R_ADDR;
                end
            end
            R_ADDR: begin
                outport_arvalid_o = ar_valid_sel;
                inport0_arready_o = ~rgrant_q & outport_arready_i;
                inport1_arready_o =  rgrant_q & outport_arready_i;
                if (ar_valid_sel && outport_arready_i) rstate_d = R_DATA;
            end
            R_DATA: begin
                outport_rready_o  = r_ready_sel;
                inport0_rvalid_o  = ~rgrant_q & outport_rvalid_i;
                inport1_rvalid_o  =  rgrant_q & outport_rvalid_i;
                if (outport_rvalid_i && r_ready_sel && outport_rlast_i) begin
                    rwin_d   = rgrant_q;
                    rstate_d = R_IDLE;
                end
            end
            default: rstate_d = R_IDLE;
        endcase
    end

endmodule

// File: doc/axi4_arb2.md
# axi4_arb2

Two-master to one-slave AXI4 arbiter for the 32-bit address / 32-bit data / 4-bit ID fabric. It sits upstream of the fabric's clock-domain-crossing and interconnect blocks and lets two requesters share one downstream AXI4 port. Write and read paths are arbitrated independently. Each path allows one outstanding transaction at a time, so response routing needs no ID remapping.

## Interface

Parameters:
- FIXED_PRIO, default 0: 0 = round-robin between masters; 1 = master 0 always wins ties.

Ports (name, direction, width, meaning):
- clk_i, in, 1: the single clock for all logic.
- rst_ni, in, 1: reset, asynchronous and active-low.
- inport0_* (x = 0): master x's full AXI4 slave-side bundle, identical in shape to inport1_*.
  - aw: awvalid/awaddr[31:0]/awid[3:0]/awlen[7:0]/awburst[1:0] in, awready out.
  - w: wvalid/wdata[31:0]/wstrb[3:0]/wlast in, wready out.
  - b: bvalid/bresp[1:0]/bid[3:0] out, bready in.
  - ar: arvalid/araddr[31:0]/arid[3:0]/arlen[7:0]/arburst[1:0] in, arready out.
  - r: rvalid/rdata[31:0]/rresp[1:0]/rid[3:0]/rlast out, rready in.
- inport1_* (x = 1): master 1's bundle, same shape as inport0_*.
- outport_*: master-side AXI4 bundle toward the slave, with the mirror directions of inport0_*.

## Operation

- Write FSM states: W_IDLE, W_ADDR, W_DATA, W_RESP. Read FSM states: R_IDLE, R_ADDR, R_DATA. The two FSMs are fully independent.
- W_IDLE, any inportX_awvalid_i high:
  - Pick a winner and register it in wgrant.
  - Go to W_ADDR.
  - With no request, stay in W_IDLE.
- W_ADDR:
  - outport_aw* carries the granted master's AW.
  - The granted master's awready equals outport_awready_i.
  - On the AW handshake, go to W_DATA.
- W_DATA:
  - outport_w* carries the granted master's W.
  - The granted master's wready equals outport_wready_i.
  - On a handshake with wlast = 1, go to W_RESP. awlen is not checked; only wlast ends the burst.
- W_RESP:
  - outport_b* is routed to the granted master's b* outputs.
  - outport_bready_o equals the granted master's bready.
  - On the B handshake, update the last-winner register and go to W_IDLE.
- Read FSM works the same way:
  - R_IDLE: arbitrate on arvalid.
  - R_ADDR: AR passthrough.
  - R_DATA: R routed to the granted master; leave on the R handshake with rlast = 1.
- Non-granted master and idle behaviour:
  - A non-granted master sees awready, wready, arready, bvalid and rvalid all at 0.
  - Outside W_RESP, outport_bready_o = 0; outside R_DATA, outport_rready_o = 0. A stray downstream response is therefore held off, not dropped.
- Arbitration:
  - Round-robin: when both masters request, the winner is the master that did not win last on that path.
  - Reset value of the last-winner register is 1, so master 0 wins the first tie.
  - With FIXED_PRIO = 1, master 0 always wins a tie.
  - A single requester always wins.
- Payload muxes select by wgrant/rgrant and are don't-care when the matching valid is 0.

## Timing

- Reset (asynchronous assert, synchronous release):
  - Both FSMs return to IDLE; wgrant = rgrant = 0; both last-winner registers = 1.
  - All valid/ready outputs are 0 during and after reset: inport*_awready/wready/arready/bvalid/rvalid and outport_awvalid/wvalid/arvalid/bready/rready.
- Reset mid-transaction abandons the transfer. Downstream logic must be reset together with this block.
- Arbitration latency:
  - Request seen in IDLE at cycle N; grant registered at N+1; outport_*valid is high from N+1.
  - From an IDLE entry, there is one bubble cycle before the next grant.
- Valid/ready are combinational passthrough from the granted side.
- There is no combinational path between the two masters.
- W beats that arrive before their AW are stalled (wready = 0), as AXI permits.
- Write minimum: 4 cycles from awvalid to B handshake, for a 1-beat burst with all readies high.
- Read minimum: 3 cycles from arvalid for a 1-beat read.

## Structure

- Package axi4_arb_pkg holds:
  - localparams ADDR_W = 32, DATA_W = 32, ID_W = 4, LEN_W = 8;
  - enums for the write and read FSM states.
- Sub-module axi4_arb_rr2: a 2-way picker.
  - Inputs: req[1:0], last, fixed_prio. Output: winner.
  - Combinational; instantiated twice, once per path.
- Top level: two FSMs plus the payload muxes.

## Test plan

- Single write: m0 issues AW addr 0x1000, id 3, len 3, with 4 W beats; slave is always ready.
  - Required: outport sees the same AW and 4 beats with wlast on beat 4.
  - m0 receives bid 3, bresp 0.
  - m1's awready, wready and bvalid stay 0 throughout.
- Simultaneous AR: m0 and m1 assert arvalid in the same cycle, three times in a row.
  - Required: grants go m0, m1, m0.
  - With FIXED_PRIO = 1, all grants go to m0 while m0 keeps requesting.
- Read burst: m1 reads len 7 with rready toggling every cycle.
  - Required: m1 receives 8 beats in order with rlast on beat 8.
  - The FSM returns to R_IDLE one cycle after the rlast handshake.
- Concurrent paths: m0 writes while m1 reads.
  - Required: both complete with no stall from each other.
  - outport_awvalid and outport_arvalid are high in the same cycle.
- Backpressure and stray response:
  - Slave bvalid held for 5 cycles while m0 keeps bready = 0: m0 bvalid stays 1 and bid is stable; no loss.
  - Stray bvalid in W_IDLE: outport_bready_o stays 0.
- Reset mid-burst: assert rst_ni low during beat 2 of 4.
  - Required: all valid/ready outputs are 0 asynchronously.
  - After release, m0 wins the first tie.
